// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard codes, mul/div FSM encoding, control bundle.
// No logic or latency of its own.
// No flow control; types only.
package pipe_pkg;

    localparam logic [1:0] NORMAL = 2'b00;
    localparam logic [1:0] FLUSH  = 2'b01;
    localparam logic [1:0] STALL  = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    typedef struct packed {
        logic       keep_pc;
        logic [1:0] if_id;
        logic       id_ex;
    } hz_ctl_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks occupancy of the multi-cycle mul/div unit.
// Busy for exactly MD_LAT cycles, starting the cycle after an accepted start.
// No backpressure; start must already be qualified by the caller.
module md_busy_tracker #(
    parameter int MD_LAT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic md_busy
);
    import pipe_pkg::*;

    localparam logic [5:0] MD_INIT = 6'(MD_LAT - 1);

    md_state_t  state, state_nxt;
    logic [5:0] md_cnt, md_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            md_cnt <= 6'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        md_busy    = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt  = MD_BUSY;
                    md_cnt_nxt = MD_INIT;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                // Last busy cycle is the one where the counter reads zero.
                if (md_cnt == 6'd0) begin
                    state_nxt = MD_IDLE;
                end else begin
                    md_cnt_nxt = md_cnt - 6'd1;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use and mul/div interlocks, branch/jump/exception flush control.
// Control outputs are combinational (zero latency); load and mul/div tracking is registered.
// Asserts keep_pc/stall to back-pressure IF and ID; exceptions override stalls.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 8,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_md_start,
    input  logic              id_md_read,
    input  logic              ex_mem_rd,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              branch,
    input  logic              jump,
    input  logic              exc_flush,
    output logic              keep_pc,
    output logic [1:0]        hazard_if_id,
    output logic              hazard_id_ex,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);
    import pipe_pkg::*;

    localparam logic [1:0] LD_INIT = 2'(LOAD_LAT - 1);

    logic [REG_AW-1:0] ld_dst;
    logic [1:0]        ld_cnt;
    logic              load_hz;
    logic              md_hz;
    logic              stall;
    logic              md_start;
    hz_ctl_t           ctl;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic src_match(input logic [REG_AW-1:0] r);
        return (r != '0) && ((id_use_rs && (id_rs == r)) || (id_use_rt && (id_rt == r)));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_dst <= '0;
            ld_cnt <= 2'd0;
        end else if (ex_mem_rd && !exc_flush) begin
            ld_dst <= ex_rt;
            ld_cnt <= LD_INIT;
        end else if (ld_cnt != 2'd0) begin
            ld_cnt <= ld_cnt - 2'd1;
        end
    end

    assign load_hz  = (ex_mem_rd && src_match(ex_rt)) || ((ld_cnt != 2'd0) && src_match(ld_dst));
    assign md_hz    = md_busy && (id_md_start || id_md_read);
    assign stall    = load_hz || md_hz;
    assign md_start = id_md_start && !stall && !exc_flush;

    md_busy_tracker #(
        .MD_LAT (MD_LAT)
    ) u_md_busy_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (md_start),
        .md_busy (md_busy)
    );

    always_comb begin
        ctl = '{keep_pc: 1'b0, if_id: NORMAL, id_ex: 1'b0};
        if (exc_flush) begin
            ctl = '{keep_pc: 1'b0, if_id: FLUSH, id_ex: 1'b1};
        end else if (stall) begin
            ctl = '{keep_pc: 1'b1, if_id: STALL, id_ex: 1'b1};
        end else if (branch) begin
            ctl = '{keep_pc: 1'b0, if_id: FLUSH, id_ex: 1'b1};
        end else if (jump) begin
            // Jump delay slot is already in ID/EX, so only IF/ID is squashed.
            ctl = '{keep_pc: 1'b0, if_id: FLUSH, id_ex: 1'b0};
        end
    end

    assign keep_pc      = ctl.keep_pc;
    assign hazard_if_id = ctl.if_id;
    assign hazard_id_ex = ctl.id_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !exc_flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: instance a uses LOAD_LAT=1, instance b uses LOAD_LAT=3 with a 2-bit stall counter.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_use_rs, id_use_rt, id_md_start, id_md_read;
    logic       ex_mem_rd, branch, jump, exc_flush;

    logic        a_keep_pc, a_id_ex, a_md_busy;
    logic [1:0]  a_if_id;
    logic [31:0] a_stall_cnt;
    logic        b_keep_pc, b_id_ex, b_md_busy;
    logic [1:0]  b_if_id;
    logic [1:0]  b_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .MD_LAT(8), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_md_start(id_md_start), .id_md_read(id_md_read),
        .ex_mem_rd(ex_mem_rd), .ex_rt(ex_rt), .branch(branch), .jump(jump),
        .exc_flush(exc_flush), .keep_pc(a_keep_pc), .hazard_if_id(a_if_id),
        .hazard_id_ex(a_id_ex), .md_busy(a_md_busy), .stall_cnt(a_stall_cnt)
    );

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .MD_LAT(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_md_start(id_md_start), .id_md_read(id_md_read),
        .ex_mem_rd(ex_mem_rd), .ex_rt(ex_rt), .branch(branch), .jump(jump),
        .exc_flush(exc_flush), .keep_pc(b_keep_pc), .hazard_if_id(b_if_id),
        .hazard_id_ex(b_id_ex), .md_busy(b_md_busy), .stall_cnt(b_stall_cnt)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       ld;
        logic [4:0] ld_rt;
        logic       br;
        logic       jmp;
        logic       exc;
        logic       exp_keep;
        logic [1:0] exp_if_id;
        logic       exp_id_ex;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_md_start = 1'b0; id_md_read = 1'b0;
        ex_mem_rd = 1'b0; branch = 1'b0; jump = 1'b0; exc_flush = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nst;
        int nbusy;

        // rs, rt, use_rs, use_rt, ld, ld_rt, br, jmp, exc -> keep, if_id, id_ex
        vt[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        vt[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
        vt[2]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        vt[3]  = '{5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
        vt[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        vt[5]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1};
        vt[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
        vt[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1};
        vt[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
        vt[9]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
        vt[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
        vt[11] = '{5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
        vt[12] = '{5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};

        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("reset keep_pc", 32'(a_keep_pc), 32'd0);
        chk("reset if_id", 32'(a_if_id), 32'd0);
        chk("reset id_ex", 32'(a_id_ex), 32'd0);
        chk("reset md_busy", 32'(a_md_busy), 32'd0);
        chk("reset stall_cnt", a_stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle vectors against instance a (its load tracker never holds state).
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            id_rs = vt[i].rs; id_rt = vt[i].rt;
            id_use_rs = vt[i].use_rs; id_use_rt = vt[i].use_rt;
            ex_mem_rd = vt[i].ld; ex_rt = vt[i].ld_rt;
            branch = vt[i].br; jump = vt[i].jmp; exc_flush = vt[i].exc;
            #1;
            chk($sformatf("vec%0d keep_pc", i), 32'(a_keep_pc), 32'(vt[i].exp_keep));
            chk($sformatf("vec%0d if_id", i), 32'(a_if_id), 32'(vt[i].exp_if_id));
            chk($sformatf("vec%0d id_ex", i), 32'(a_id_ex), 32'(vt[i].exp_id_ex));
        end

        // Load r5, use rs=5, LOAD_LAT=1: one stall then normal.
        do_reset();
        @(negedge clk);
        ex_mem_rd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
        #1;
        chk("ld1 stall keep_pc", 32'(a_keep_pc), 32'd1);
        chk("ld1 stall if_id", 32'(a_if_id), 32'(2'b10));
        @(negedge clk);
        ex_mem_rd = 1'b0;
        #1;
        chk("ld1 release keep_pc", 32'(a_keep_pc), 32'd0);
        chk("ld1 release if_id", 32'(a_if_id), 32'd0);
        chk("ld1 release id_ex", 32'(a_id_ex), 32'd0);

        // Load r5, use rt=5, LOAD_LAT=3: three stalls, counter saturates at 3.
        do_reset();
        @(negedge clk);
        ex_mem_rd = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1;
        nst = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (b_keep_pc) nst++;
            @(negedge clk);
            ex_mem_rd = 1'b0;
        end
        chk("ld3 stall cycles", 32'(nst), 32'd3);
        chk("ld3 stall_cnt", 32'(b_stall_cnt), 32'd3);
        chk("ld3 lat1 stall_cnt", a_stall_cnt, 32'd1);
        chk("ld3 release if_id", 32'(b_if_id), 32'd0);
        ex_mem_rd = 1'b1;
        #1;
        chk("ld3 again stall", 32'(b_keep_pc), 32'd1);
        @(negedge clk);
        ex_mem_rd = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_cnt saturate", 32'(b_stall_cnt), 32'd3);

        // Flush after a load does not clear the outstanding load counter.
        do_reset();
        @(negedge clk);
        ex_mem_rd = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_use_rt = 1'b0;
        @(negedge clk);
        ex_mem_rd = 1'b0; id_use_rt = 1'b1; exc_flush = 1'b1;
        #1;
        chk("flush over load if_id", 32'(b_if_id), 32'(2'b01));
        @(negedge clk);
        exc_flush = 1'b0;
        #1;
        chk("load survives flush", 32'(b_keep_pc), 32'd1);
        @(negedge clk);
        #1;
        chk("flush cycle not counted", 32'(b_stall_cnt), 32'd1);

        // Mult accepted, mflo next cycle: 8 busy/stall cycles.
        do_reset();
        @(negedge clk);
        id_md_start = 1'b1;
        #1;
        chk("md accept busy", 32'(a_md_busy), 32'd0);
        chk("md accept keep_pc", 32'(a_keep_pc), 32'd0);
        @(negedge clk);
        id_md_start = 1'b0; id_md_read = 1'b1;
        nst = 0; nbusy = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (a_md_busy) nbusy++;
            if (a_keep_pc) nst++;
            @(negedge clk);
        end
        chk("md busy cycles", 32'(nbusy), 32'd8);
        chk("mflo stall cycles", 32'(nst), 32'd8);
        chk("md stall_cnt", a_stall_cnt, 32'd8);
        chk("mflo proceeds", 32'(a_if_id), 32'd0);
        id_md_read = 1'b0;

        // Reset mid-BUSY aborts the operation.
        do_reset();
        @(negedge clk);
        id_md_start = 1'b1;
        @(negedge clk);
        id_md_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("md busy before reset", 32'(a_md_busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset aborts md_busy", 32'(a_md_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        id_md_read = 1'b1;
        #1;
        chk("mfhi after reset keep_pc", 32'(a_keep_pc), 32'd0);
        @(negedge clk);
        #1;
        chk("mfhi after reset md_busy", 32'(a_md_busy), 32'd0);
        chk("mfhi after reset if_id", 32'(a_if_id), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
